// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing constants for the result-bus arbiter and its
// per-producer skid FIFOs.
package cdb_arbiter_pkg;

    localparam int ROB_ID_WIDTH   = 5;
    localparam int NUM_PREGS      = 64;
    localparam int PREG_WIDTH     = $clog2(NUM_PREGS);
    localparam int NUM_EXEC_UNITS = 6;
    localparam int NUM_CDB_PORTS  = NUM_EXEC_UNITS;
    localparam int CDB_LANES      = 2;
    localparam int CDB_BUF_DEPTH  = 2;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             data;
        logic [PREG_WIDTH-1:0]   preg;
        logic [ROB_ID_WIDTH-1:0] rob_id;
    } cdb_t;

    // Distance of a ROB tag from the head, accounting for wrap at depth.
    function automatic int unsigned rob_age(input int unsigned rob_id,
                                            input int unsigned head,
                                            input int unsigned depth);
        return (rob_id >= head) ? rob_id - head : rob_id + depth - head;
    endfunction

endpackage

// File: rtl/cdb_unit_fifo.sv
// Single-producer skid FIFO feeding one arbiter input; ready depends only on
// registered occupancy.
module cdb_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 43
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic         ready,
    output logic         not_empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_data;
    end

    assign ready     = (count < CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_LANES producer FIFO heads per cycle
// onto registered CDB lanes. Define CDB_AGE_PRIO_EN for oldest-ROB-first order.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = NUM_CDB_PORTS,
    parameter int NUM_LANES = CDB_LANES,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH,
    parameter int PREG_W    = PREG_WIDTH,
    parameter int ROB_ID_W  = ROB_ID_WIDTH,
    parameter int ROB_DEPTH = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_UNITS-1:0]                unit_valid_i,
    output logic [NUM_UNITS-1:0]                unit_ready_o,
    input  logic [NUM_UNITS-1:0][31:0]          unit_data_i,
    input  logic [NUM_UNITS-1:0][PREG_W-1:0]    unit_preg_i,
    input  logic [NUM_UNITS-1:0][ROB_ID_W-1:0]  unit_rob_id_i,
    input  logic                                flush_i,
    input  logic [ROB_ID_W-1:0]                 rob_head_i,
    output cdb_t [NUM_LANES-1:0]                cdb_o,
    output logic [31:0]                         stall_cnt_o
);

    localparam int ENTRY_W = 32 + PREG_W + ROB_ID_W;
    localparam int RR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0] fifo_ready;
    logic [NUM_UNITS-1:0] not_empty;
    logic [NUM_UNITS-1:0] enq;
    logic [NUM_UNITS-1:0] grant;
    logic [ENTRY_W-1:0]   head [NUM_UNITS];
    int unsigned          key  [NUM_UNITS];
    int unsigned          rank [NUM_UNITS];
    int unsigned          n_grant;
    logic [RR_W-1:0]      rr_ptr;
    logic [RR_W-1:0]      rr_next;
    cdb_t [NUM_LANES-1:0] cdb_next;
    logic [31:0]          stall_cnt;

    assign unit_ready_o = fifo_ready;
    assign enq          = unit_valid_i & fifo_ready & {NUM_UNITS{~flush_i}};
    assign stall_cnt_o  = stall_cnt;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_fifo
        cdb_unit_fifo #(
            .DEPTH (BUF_DEPTH),
            .W     (ENTRY_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_i),
            .enq       (enq[g]),
            .enq_data  ({unit_data_i[g], unit_preg_i[g], unit_rob_id_i[g]}),
            .deq       (grant[g]),
            .ready     (fifo_ready[g]),
            .not_empty (not_empty[g]),
            .head      (head[g])
        );
    end

    // Each unit gets a unique priority key; lower key wins an earlier lane.
    always_comb begin
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
`ifdef CDB_AGE_PRIO_EN
            key[u] = rob_age(32'(head[u][ROB_ID_W-1:0]), 32'(rob_head_i), ROB_DEPTH)
                     * NUM_UNITS + u;
`else
            key[u] = (u + NUM_UNITS - 32'(rr_ptr)) % NUM_UNITS;
`endif
        end
    end

    // A unit's lane is its rank among non-empty units; ranks past NUM_LANES lose.
    always_comb begin
        grant    = '0;
        n_grant  = 0;
        rr_next  = rr_ptr;
        cdb_next = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            rank[u] = 0;
            for (int unsigned v = 0; v < NUM_UNITS; v++) begin
                if (not_empty[v] && key[v] < key[u]) rank[u] = rank[u] + 1;
            end
        end
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (not_empty[u] && rank[u] < NUM_LANES) begin
                grant[u] = 1'b1;
                n_grant  = n_grant + 1;
            end
        end
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (grant[u] && rank[u] + 1 == n_grant) rr_next = RR_W'((u + 1) % NUM_UNITS);
        end
`ifdef CDB_AGE_PRIO_EN
        rr_next = '0;
`endif
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                if (grant[u] && rank[u] == l) begin
                    cdb_next[l].valid  = 1'b1;
                    cdb_next[l].data   = head[u][ENTRY_W-1 -: 32];
                    cdb_next[l].preg   = head[u][ROB_ID_W +: PREG_W];
                    cdb_next[l].rob_id = head[u][ROB_ID_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_o     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else if (flush_i) begin
            cdb_o <= '0;
        end else begin
            cdb_o  <= cdb_next;
            rr_ptr <= rr_next;
            if (|(not_empty & ~grant) && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef CDB_AGE_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^rr_ptr;
`else
    logic unused_age_cfg;
    assign unused_age_cfg = ^{rob_head_i, 32'(ROB_DEPTH)};
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter against a queue-based model
// of the round-robin CDB arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NU  = 6;
    localparam int NL  = 2;
    localparam int BUF = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NU-1:0]         unit_valid_i;
    logic [NU-1:0]         unit_ready_o;
    logic [NU-1:0][31:0]   unit_data_i;
    logic [NU-1:0][5:0]    unit_preg_i;
    logic [NU-1:0][4:0]    unit_rob_id_i;
    logic                  flush_i;
    logic [4:0]            rob_head_i;
    cdb_t [NL-1:0]         cdb_o;
    logic [31:0]           stall_cnt_o;

    cdb_arbiter #(
        .NUM_UNITS (NU),
        .NUM_LANES (NL),
        .BUF_DEPTH (BUF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .unit_valid_i  (unit_valid_i),
        .unit_ready_o  (unit_ready_o),
        .unit_data_i   (unit_data_i),
        .unit_preg_i   (unit_preg_i),
        .unit_rob_id_i (unit_rob_id_i),
        .flush_i       (flush_i),
        .rob_head_i    (rob_head_i),
        .cdb_o         (cdb_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    cdb_t        q [NU][$];
    int          rr;
    logic [31:0] m_stall;
    cdb_t        exp_cdb [NL];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input cdb_t obs, input cdb_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) q[u].delete();
        rr      = 0;
        m_stall = '0;
        for (int l = 0; l < NL; l++) exp_cdb[l] = '0;
    endtask

    // One clock edge of the arbiter, expressed as operations on per-unit queues.
    task automatic model_edge();
        logic [NU-1:0] acc;
        int   n;
        int   last;
        bit   pend;
        cdb_t e;
        n = 0; last = 0; pend = 0;
        for (int l = 0; l < NL; l++) exp_cdb[l] = '0;
        if (flush_i) begin
            for (int u = 0; u < NU; u++) q[u].delete();
        end else begin
            for (int u = 0; u < NU; u++) acc[u] = unit_valid_i[u] && (q[u].size() < BUF);
            for (int k = 0; k < NU; k++) begin
                int u;
                u = (rr + k) % NU;
                if (q[u].size() > 0) begin
                    if (n < NL) begin
                        exp_cdb[n] = q[u].pop_front();
                        n++;
                        last = u;
                    end else begin
                        pend = 1;
                    end
                end
            end
            if (n > 0) rr = (last + 1) % NU;
            if (pend && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            for (int u = 0; u < NU; u++) begin
                if (acc[u]) begin
                    e.valid  = 1'b1;
                    e.data   = unit_data_i[u];
                    e.preg   = unit_preg_i[u];
                    e.rob_id = unit_rob_id_i[u];
                    q[u].push_back(e);
                end
            end
        end
    endtask

    task automatic cycle();
        logic [NU-1:0] exp_ready;
        for (int u = 0; u < NU; u++) exp_ready[u] = (q[u].size() < BUF);
        chk32("ready", 32'(unit_ready_o), 32'(exp_ready));
        model_edge();
        @(posedge clk);
        #1;
        chk_cdb("lane0", cdb_o[0], exp_cdb[0]);
        chk_cdb("lane1", cdb_o[1], exp_cdb[1]);
        chk32("stall_cnt", stall_cnt_o, m_stall);
    endtask

    task automatic idle();
        unit_valid_i = '0;
        flush_i      = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [31:0] d, input logic [5:0] p, input logic [4:0] r);
        unit_valid_i[u]  = 1'b1;
        unit_data_i[u]   = d;
        unit_preg_i[u]   = p;
        unit_rob_id_i[u] = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        cdb_t exp1;
        rst           = 1'b1;
        unit_valid_i  = '0;
        unit_data_i   = '0;
        unit_preg_i   = '0;
        unit_rob_id_i = '0;
        flush_i       = 1'b0;
        rob_head_i    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cdb("rst_lane0", cdb_o[0], '0);
        chk_cdb("rst_lane1", cdb_o[1], '0);
        chk32("rst_stall", stall_cnt_o, 32'd0);
        chk32("rst_ready", 32'(unit_ready_o), 32'h3F);
        rst = 1'b0;

        // Single push on unit 3: visible on lane 0 two edges later.
        set_unit(3, 32'hDEAD_BEEF, 6'd17, 5'd5);
        cycle();
        idle();
        cycle();
        exp1 = '{valid: 1'b1, data: 32'hDEAD_BEEF, preg: 6'd17, rob_id: 5'd5};
        chk_cdb("single_lane0", cdb_o[0], exp1);
        chk32("single_lane1_valid", 32'(cdb_o[1].valid), 32'd0);
        cycle();

        // Contention: all units push once from rr_ptr = 0.
        do_reset();
        for (int u = 0; u < NU; u++) set_unit(u, 32'h1000 + u, 6'(u), 5'(u + 8));
        cycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk32("cont_lane0", cdb_o[0].data, 32'h1000 + 2 * c);
            chk32("cont_lane1", cdb_o[1].data, 32'h1001 + 2 * c);
        end
        chk32("cont_stall", stall_cnt_o, 32'd2);
        cycle();

        // Flush with four buffered entries plus a dropped enqueue.
        for (int u = 0; u < 4; u++) set_unit(u, 32'hF000 + u, 6'(u), 5'(u));
        cycle();
        unit_valid_i = 6'h20;
        unit_data_i[5] = 32'hBAD0_0005;
        flush_i = 1'b1;
        cycle();
        chk32("flush_valids", 32'({cdb_o[1].valid, cdb_o[0].valid}), 32'd0);
        idle();
        chk32("flush_ready", 32'(unit_ready_o), 32'h3F);
        chk32("flush_stall_kept", stall_cnt_o, 32'd2);
        repeat (3) cycle();

        // Backpressure: every unit floods; a full FIFO refuses even while dequeued.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int u = 0; u < NU; u++) set_unit(u, 32'h2000 + 16 * c + u, 6'(u), 5'(c));
            cycle();
            if (c == 1) chk32("bp_ready_c2", 32'(unit_ready_o), 32'h03);
            if (c == 2) chk32("bp_ready_c3", 32'(unit_ready_o), 32'h0C);
        end
        idle();
        repeat (8) cycle();

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            unit_valid_i = 6'($urandom | $urandom);
            flush_i      = ($urandom_range(0, 31) == 0);
            for (int u = 0; u < NU; u++) begin
                unit_data_i[u]   = $urandom;
                unit_preg_i[u]   = 6'($urandom);
                unit_rob_id_i[u] = 5'($urandom);
            end
            cycle();
        end

        // Asynchronous reset between edges in the middle of a burst.
        flush_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            unit_valid_i = 6'h3F;
            for (int u = 0; u < NU; u++) unit_data_i[u] = $urandom;
            cycle();
        end
        #3;
        rst = 1'b1;
        idle();
        #1;
        chk_cdb("arst_lane0", cdb_o[0], '0);
        chk_cdb("arst_lane1", cdb_o[1], '0);
        chk32("arst_stall", stall_cnt_o, 32'd0);
        chk32("arst_ready", 32'(unit_ready_o), 32'h3F);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
